// File: rtl/alu_seq.sv
// alu_seq: DLX execute-stage controller that sequences the external 32-bit ALU and splits long shifts into passes.
// Optional macro ALU_SEQ_CHAIN_EN issues follow-on shift passes directly from RESULT (one cycle per pass).
module alu_seq #(
   parameter int SHIFT_CHUNK = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   output logic [3:0]  alu_I,
   output logic        alu_EX,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   input  logic [31:0] alu_res,
   input  logic        alu_carry,
   input  logic        alu_z,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_carry,
   output logic        wb_z,
   output logic        illegal
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESULT, WB} state_t;

   localparam logic [4:0] CHUNK = 5'(SHIFT_CHUNK);

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] alu_op1_q, alu_op1_d;
   logic [31:0] alu_op2_q, alu_op2_d;
   logic [4:0]  rem_q, rem_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        wb_carry_q, wb_carry_d;
   logic        wb_z_q, wb_z_d;
   logic        illegal_q, illegal_d;
   logic        chain_issue;

   logic [5:0]  opcode, func;
   logic [3:0]  dec_op;
   logic        dec_legal, dec_rtype, dec_zext;
   logic [31:0] dec_op2;
   logic [4:0]  dec_rd;
   logic        unused_fields;

   assign unused_fields = ^{instr[25:21], instr[10:6]};

   function automatic logic is_shift(input logic [3:0] op);
      return (op == 4'd6) || (op == 4'd7) || (op == 4'd14);
   endfunction

   function automatic logic [4:0] chunk_of(input logic [4:0] r);
      return (r < CHUNK) ? r : CHUNK;
   endfunction

   // Decode to the ALU op code; anything unlisted is flagged illegal.
   always_comb begin
      opcode    = instr[31:26];
      func      = instr[5:0];
      dec_op    = 4'd0;
      dec_legal = 1'b1;
      dec_rtype = (opcode == 6'h00);
      dec_zext  = 1'b0;
      if (dec_rtype) begin
         case (func)
            6'h20: dec_op = 4'd1;
            6'h22: dec_op = 4'd2;
            6'h24: dec_op = 4'd3;
            6'h25: dec_op = 4'd4;
            6'h26: dec_op = 4'd5;
            6'h04: dec_op = 4'd6;
            6'h06: dec_op = 4'd7;
            6'h07: dec_op = 4'd14;
            6'h28: dec_op = 4'd10;
            6'h29: dec_op = 4'd13;
            6'h2A: dec_op = 4'd12;
            6'h2C: dec_op = 4'd11;
            default: dec_legal = 1'b0;
         endcase
      end else begin
         case (opcode)
            6'h08: dec_op = 4'd1;
            6'h0A: dec_op = 4'd2;
            6'h0C: begin dec_op = 4'd3; dec_zext = 1'b1; end
            6'h0D: begin dec_op = 4'd4; dec_zext = 1'b1; end
            6'h0E: begin dec_op = 4'd5; dec_zext = 1'b1; end
            6'h14: dec_op = 4'd6;
            6'h16: dec_op = 4'd7;
            6'h17: dec_op = 4'd14;
            6'h18: dec_op = 4'd10;
            6'h19: dec_op = 4'd13;
            6'h1A: dec_op = 4'd12;
            6'h1C: dec_op = 4'd11;
            default: dec_legal = 1'b0;
         endcase
      end
      if (dec_rtype)     dec_op2 = rs2_val;
      else if (dec_zext) dec_op2 = {16'h0000, instr[15:0]};
      else               dec_op2 = {{16{instr[15]}}, instr[15:0]};
      dec_rd = dec_rtype ? instr[15:11] : instr[20:16];
   end

   // rem holds the shift amount still outstanding after the pass currently loaded on alu_op2.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      alu_op1_d   = alu_op1_q;
      alu_op2_d   = alu_op2_q;
      rem_d       = rem_q;
      rd_d        = rd_q;
      wb_data_d   = wb_data_q;
      wb_carry_d  = wb_carry_q;
      wb_z_d      = wb_z_q;
      illegal_d   = 1'b0;
      chain_issue = 1'b0;
      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               if (dec_legal) begin
                  op_d      = dec_op;
                  rd_d      = dec_rd;
                  alu_op1_d = rs1_val;
                  if (is_shift(dec_op)) begin
                     alu_op2_d = {27'd0, chunk_of(dec_op2[4:0])};
                     rem_d     = dec_op2[4:0] - chunk_of(dec_op2[4:0]);
                  end else begin
                     alu_op2_d = dec_op2;
                     rem_d     = 5'd0;
                  end
                  state_d = ISSUE;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         ISSUE: state_d = RESULT;
         RESULT: begin
            if (is_shift(op_q) && (rem_q != 5'd0)) begin
               alu_op1_d = alu_res;
               alu_op2_d = {27'd0, chunk_of(rem_q)};
               rem_d     = rem_q - chunk_of(rem_q);
`ifdef ALU_SEQ_CHAIN_EN
               chain_issue = 1'b1;
               state_d     = RESULT;
`else
               state_d     = ISSUE;
`endif
            end else begin
               wb_data_d  = alu_res;
               wb_carry_d = ((op_q == 4'd1) || (op_q == 4'd2)) ? alu_carry : 1'b0;
               wb_z_d     = alu_z;
               state_d    = WB;
            end
         end
         WB: if (wb_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign instr_ready = (state_q == IDLE) && !rst;
   assign alu_EX      = (state_q == ISSUE) || chain_issue;
   assign alu_I       = alu_EX ? op_q : 4'd0;
   assign alu_op1     = chain_issue ? alu_res : alu_op1_q;
   assign alu_op2     = chain_issue ? alu_op2_d : alu_op2_q;
   assign wb_valid    = (state_q == WB);
   assign wb_data     = wb_data_q;
   assign wb_rd       = rd_q;
   assign wb_carry    = wb_carry_q;
   assign wb_z        = wb_z_q;
   assign illegal     = illegal_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= '0;
         alu_op1_q  <= '0;
         alu_op2_q  <= '0;
         rem_q      <= '0;
         rd_q       <= '0;
         wb_data_q  <= '0;
         wb_carry_q <= 1'b0;
         wb_z_q     <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         alu_op1_q  <= alu_op1_d;
         alu_op2_q  <= alu_op2_d;
         rem_q      <= rem_d;
         rd_q       <= rd_d;
         wb_data_q  <= wb_data_d;
         wb_carry_q <= wb_carry_d;
         wb_z_q     <= wb_z_d;
         illegal_q  <= illegal_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized bench for alu_seq with a behavioural ALU and an instruction-level reference model.
`timescale 1ns/1ps
module tb_alu_seq;

   localparam int CHUNK = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid, instr_ready;
   logic [31:0] instr, rs1_val, rs2_val;
   logic [3:0]  alu_I;
   logic        alu_EX;
   logic [31:0] alu_op1, alu_op2, alu_res;
   logic        alu_carry, alu_z;
   logic        wb_valid, wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_carry, wb_z, illegal;

   alu_seq #(.SHIFT_CHUNK(CHUNK)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .rs1_val(rs1_val), .rs2_val(rs2_val),
      .alu_I(alu_I), .alu_EX(alu_EX), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_res(alu_res), .alu_carry(alu_carry), .alu_z(alu_z),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
      .wb_carry(wb_carry), .wb_z(wb_z), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ALU semantics: {carry, result}; set-ops give all-ones for true.
   function automatic logic [32:0] aluCompute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] r;
      logic [31:0] sra;
      r   = '0;
      sra = $signed(a) >>> b[4:0];
      case (op)
         4'd1:  r = {1'b0, a} + {1'b0, b};
         4'd2:  r = {1'b0, a} + {1'b0, ~b} + 33'd1;
         4'd3:  r = {1'b0, a & b};
         4'd4:  r = {1'b0, a | b};
         4'd5:  r = {1'b0, a ^ b};
         4'd6:  r = {1'b0, a << b[4:0]};
         4'd7:  r = {1'b0, a >> b[4:0]};
         4'd14: r = {1'b0, sra};
         4'd10: r = {1'b0, (a == b) ? 32'hFFFF_FFFF : 32'h0};
         4'd13: r = {1'b0, (a != b) ? 32'hFFFF_FFFF : 32'h0};
         4'd12: r = {1'b0, ($signed(a) <  $signed(b)) ? 32'hFFFF_FFFF : 32'h0};
         4'd11: r = {1'b0, ($signed(a) <= $signed(b)) ? 32'hFFFF_FFFF : 32'h0};
         default: r = '0;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin : alu_model
      logic [32:0] t;
      if (rst) begin
         alu_res   <= '0;
         alu_carry <= 1'b0;
         alu_z     <= 1'b0;
      end else if (alu_EX) begin
         t = aluCompute(alu_I, alu_op1, alu_op2);
         alu_res   <= t[31:0];
         alu_carry <= t[32];
         alu_z     <= (t[31:0] == 32'd0);
      end
   end

   logic [31:0] exOp1[$];
   logic [31:0] exOp2[$];
   logic [3:0]  exCode[$];

   always @(negedge clk) begin
      if (alu_EX) begin
         exOp1.push_back(alu_op1);
         exOp2.push_back(alu_op2);
         exCode.push_back(alu_I);
      end
   end

   typedef struct {
      logic       rtype;
      logic [5:0] code;
      logic [3:0] op;
      logic       zext;
   } ins_t;

   ins_t tbl[$];

   function automatic ins_t mk(input logic rtype, input logic [5:0] code, input logic [3:0] op, input logic zext);
      ins_t e;
      e.rtype = rtype; e.code = code; e.op = op; e.zext = zext;
      return e;
   endfunction

   task automatic buildTable();
      tbl.push_back(mk(1, 6'h20, 4'd1, 0));  tbl.push_back(mk(1, 6'h22, 4'd2, 0));
      tbl.push_back(mk(1, 6'h24, 4'd3, 0));  tbl.push_back(mk(1, 6'h25, 4'd4, 0));
      tbl.push_back(mk(1, 6'h26, 4'd5, 0));  tbl.push_back(mk(1, 6'h04, 4'd6, 0));
      tbl.push_back(mk(1, 6'h06, 4'd7, 0));  tbl.push_back(mk(1, 6'h07, 4'd14, 0));
      tbl.push_back(mk(1, 6'h28, 4'd10, 0)); tbl.push_back(mk(1, 6'h29, 4'd13, 0));
      tbl.push_back(mk(1, 6'h2A, 4'd12, 0)); tbl.push_back(mk(1, 6'h2C, 4'd11, 0));
      tbl.push_back(mk(0, 6'h08, 4'd1, 0));  tbl.push_back(mk(0, 6'h0A, 4'd2, 0));
      tbl.push_back(mk(0, 6'h0C, 4'd3, 1));  tbl.push_back(mk(0, 6'h0D, 4'd4, 1));
      tbl.push_back(mk(0, 6'h0E, 4'd5, 1));  tbl.push_back(mk(0, 6'h14, 4'd6, 0));
      tbl.push_back(mk(0, 6'h16, 4'd7, 0));  tbl.push_back(mk(0, 6'h17, 4'd14, 0));
      tbl.push_back(mk(0, 6'h18, 4'd10, 0)); tbl.push_back(mk(0, 6'h19, 4'd13, 0));
      tbl.push_back(mk(0, 6'h1A, 4'd12, 0)); tbl.push_back(mk(0, 6'h1C, 4'd11, 0));
   endtask

   // Offer one instruction, predict its outcome from the instruction-level rules, and check everything seen.
   task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input int hold);
      ins_t        e;
      logic        found;
      logic [31:0] op2, expData;
      logic [32:0] full;
      logic [4:0]  expRd;
      logic        expCarry;
      int          rem, c, lat, expLat;
      logic [31:0] expChunks[$];

      found = 1'b0;
      e = mk(0, 6'h00, 4'd0, 0);
      foreach (tbl[i]) begin
         if (tbl[i].rtype == (ins[31:26] == 6'h00) &&
             tbl[i].code == (tbl[i].rtype ? ins[5:0] : ins[31:26])) begin
            found = 1'b1;
            e = tbl[i];
         end
      end
      if (e.rtype)     op2 = b;
      else if (e.zext) op2 = {16'h0000, ins[15:0]};
      else             op2 = {{16{ins[15]}}, ins[15:0]};
      expRd    = e.rtype ? ins[15:11] : ins[20:16];
      full     = aluCompute(e.op, a, op2);
      expData  = full[31:0];
      expCarry = (e.op == 4'd1 || e.op == 4'd2) ? full[32] : 1'b0;
      expChunks.delete();
      if (e.op == 4'd6 || e.op == 4'd7 || e.op == 4'd14) begin
         rem = int'(op2[4:0]);
         do begin
            c = (rem < CHUNK) ? rem : CHUNK;
            expChunks.push_back(32'(c));
            rem -= c;
         end while (rem > 0);
      end else begin
         expChunks.push_back(op2);
      end
`ifdef ALU_SEQ_CHAIN_EN
      expLat = expChunks.size() + 2;
`else
      expLat = 2 * expChunks.size() + 1;
`endif

      @(negedge clk);
      checkOutput("ready_before", instr_ready, 1);
      instr = ins; rs1_val = a; rs2_val = b; instr_valid = 1'b1;
      exOp1.delete(); exOp2.delete(); exCode.delete();
      @(posedge clk);
      #1;
      instr_valid = 1'b0; instr = $urandom; rs1_val = $urandom; rs2_val = $urandom;
      wb_ready = 1'($urandom_range(0, 1));

      if (!found) begin
         @(negedge clk);
         checkOutput("illegal_pulse", illegal, 1);
         checkOutput("illegal_ready", instr_ready, 1);
         checkOutput("illegal_ex", alu_EX, 0);
         @(negedge clk);
         checkOutput("illegal_clear", illegal, 0);
         checkOutput("illegal_wbv", wb_valid, 0);
         checkOutput("illegal_nopass", exOp2.size(), 0);
         wb_ready = 1'b0;
         return;
      end

      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         wb_ready = wb_valid ? 1'b0 : 1'($urandom_range(0, 1));
      end while (!wb_valid && lat < 64);
      wb_ready = 1'b0;

      checkOutput("latency", lat, expLat);
      checkOutput("wb_data", wb_data, expData);
      checkOutput("wb_rd", wb_rd, expRd);
      checkOutput("wb_carry", wb_carry, expCarry);
      checkOutput("wb_z", wb_z, expData == 32'd0);
      checkOutput("pass_count", exOp2.size(), expChunks.size());
      if (exOp1.size() > 0) checkOutput("pass0_op1", exOp1[0], a);
      for (int i = 0; i < expChunks.size() && i < exOp2.size(); i++) begin
         checkOutput($sformatf("pass%0d_op2", i), exOp2[i], expChunks[i]);
         checkOutput($sformatf("pass%0d_code", i), exCode[i], e.op);
      end

      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checkOutput("hold_valid", wb_valid, 1);
         checkOutput("hold_data", wb_data, expData);
         checkOutput("hold_rd", wb_rd, expRd);
         checkOutput("hold_ready", instr_ready, 0);
      end
      wb_ready = 1'b1;
      @(posedge clk);
      #1 wb_ready = 1'b0;
      @(negedge clk);
      checkOutput("wb_released", wb_valid, 0);
      checkOutput("ready_back", instr_ready, 1);
   endtask

   function automatic logic [31:0] makeIllegal();
      logic [5:0] bad[4];
      logic [31:0] w;
      bad[0] = 6'h3F; bad[1] = 6'h01; bad[2] = 6'h09; bad[3] = 6'h1B;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w = {6'h00, w[25:6], 6'h21};
      else w[31:26] = bad[$urandom_range(0, 3)];
      return w;
   endfunction

   initial begin
      buildTable();
      rst = 1'b1; instr_valid = 1'b0; instr = '0; rs1_val = '0; rs2_val = '0; wb_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_ready", instr_ready, 1);
      checkOutput("rst_wbv", wb_valid, 0);
      checkOutput("rst_ex", alu_EX, 0);
      checkOutput("rst_op1", alu_op1, 0);
      checkOutput("rst_wbdata", wb_data, 0);
      checkOutput("rst_illegal", illegal, 0);

      applyStimulus({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'hFFFF_FFFF, 32'd1, 0);
      applyStimulus({6'h14, 5'd1, 5'd4, 16'd31}, 32'd1, 32'd0, 0);
      applyStimulus({6'h17, 5'd1, 5'd5, 16'd8}, 32'h8000_0000, 32'd0, 1);
      applyStimulus({6'h1A, 5'd1, 5'd6, 16'h0009}, 32'd5, 32'd0, 0);
      applyStimulus({6'h0C, 5'd1, 5'd7, 16'h8000}, 32'hFFFF_FFFF, 32'd0, 0);
      applyStimulus({6'h14, 5'd1, 5'd8, 16'd0}, 32'hDEAD_BEEF, 32'd0, 0);
      applyStimulus({6'h3F, 26'd0}, 32'd1, 32'd2, 0);
      applyStimulus({6'h08, 5'd1, 5'd9, 16'h0234}, 32'h0000_1000, 32'd0, 5);
      applyStimulus({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h22}, 32'd3, 32'd7, 0);

      // Abort a long shift mid-flight with reset and confirm a clean idle state.
      @(negedge clk);
      instr = {6'h14, 5'd1, 5'd4, 16'd31}; rs1_val = 32'd1; instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_wbv", wb_valid, 0);
      checkOutput("midrst_ex", alu_EX, 0);
      checkOutput("midrst_code", alu_I, 0);
      checkOutput("midrst_ready", instr_ready, 1);
      checkOutput("midrst_op1", alu_op1, 0);
      checkOutput("midrst_op2", alu_op2, 0);
      @(negedge clk);
      checkOutput("midrst_stay", alu_EX, 0);

      for (int k = 0; k < 80; k++) begin
         ins_t        e;
         logic [31:0] w;
         if ($urandom_range(0, 9) == 0) begin
            w = makeIllegal();
         end else begin
            e = tbl[$urandom_range(0, tbl.size() - 1)];
            w = $urandom;
            if (e.rtype) w = {6'h00, w[25:6], e.code};
            else         w[31:26] = e.code;
         end
         applyStimulus(w, $urandom, $urandom, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Execute-stage controller for the 32-bit DLX ALU.
- Accepts one decoded-operand instruction per transaction over a valid/ready handshake and maps the DLX opcode/func to the ALU's 4-bit op code.
- Drives the ALU operands and EX strobe, then returns the result over a second valid/ready handshake.
- Shift amounts above the ALU's per-pass limit (op2 mod 8) are split into multiple chained ALU passes.

Parameters:
SHIFT_CHUNK, 7, max shift applied per ALU pass; legal range 1..7.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept
instr  in  32  DLX instruction word
rs1_val  in  32  source-1 register value
rs2_val  in  32  source-2 register value (R-type)
alu_I  out  4  ALU op code
alu_EX  out  1  ALU capture strobe
alu_op1  out  32  ALU operand 1
alu_op2  out  32  ALU operand 2
alu_res  in  32  ALU registered result
alu_carry  in  1  ALU registered carry
alu_z  in  1  ALU registered zero flag
wb_valid  out  1  result available
wb_ready  in  1  consumer accepts result
wb_data  out  32  result
wb_rd  out  5  destination register
wb_carry  out  1  carry; 0 unless ADD/SUB
wb_z  out  1  zero flag of final pass
illegal  out  1  one-cycle pulse: undecodable instruction dropped

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset, applied at any time including mid-operation:
  - state returns to IDLE; in-flight op dropped;
  - all outputs 0 except instr_ready=1 after the reset cycle.
- Decode, R-type (opcode instr[31:26]=0, func instr[5:0]):
  - 0x20 ADD→1, 0x22 SUB→2, 0x24 AND→3, 0x25 OR→4, 0x26 XOR→5
  - 0x04 SLL→6, 0x06 SRL→7, 0x07 SRA→14
  - 0x28 SEQ→10, 0x29 SNE→13, 0x2A SLT→12, 0x2C SLE→11
  - op2=rs2_val; rd=instr[15:11].
- Decode, I-type opcodes:
  - 0x08 ADDI, 0x0A SUBI, 0x0C ANDI, 0x0D ORI, 0x0E XORI
  - 0x14 SLLI, 0x16 SRLI, 0x17 SRAI
  - 0x18 SEQI, 0x19 SNEI, 0x1A SLTI, 0x1C SLEI
  - same ALU codes as the R-type equivalents; rd=instr[20:16].
  - op2=imm16, zero-extended for ANDI/ORI/XORI, sign-extended otherwise.
- Any other encoding is illegal:
  - illegal=1 for the cycle after the handshake; no ALU activity, no writeback; remain IDLE.
- States: IDLE, ISSUE, RESULT, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready: latch op code, rs1_val, op2, rd, shift remainder rem=op2[4:0].
  - → ISSUE (illegal: stay IDLE).
- ISSUE:
  - alu_EX=1, alu_I=op code, alu_op1=current op1.
  - alu_op2 = min(rem,SHIFT_CHUNK) for shifts, latched op2 otherwise.
  - rem -= chunk.
  - → RESULT.
- RESULT:
  - alu_EX=0; alu_res/alu_carry/alu_z are valid.
  - Shift with rem≠0: op1←alu_res, → ISSUE.
  - Otherwise capture wb_data, wb_carry (alu_carry only for ADD/SUB, else 0) and wb_z, → WB.
- WB:
  - wb_valid=1; wb_* held stable until wb_ready.
  - On wb_valid&wb_ready → IDLE; instr_ready rises the following cycle.
- Passes:
  - Shift amount 0: one pass with alu_op2=0.
  - Otherwise number of passes N=ceil(amt/SHIFT_CHUNK); amt=31 with chunk 7 gives passes 7,7,7,7,3 (N=5).
  - Non-shift ops: N=1.
- Latency: wb_valid first high 2N+1 cycles after the accept cycle.
- Outside ISSUE: alu_EX=0, alu_I=0, operands hold last values.
- wb_ready high while not in WB: ignored.
- rd=0 is written back like any other rd.

Optional Feature:
ALU_SEQ_CHAIN_EN
- Defined:
  - A RESULT cycle with rem≠0 also issues the next pass in the same cycle: alu_EX=1, alu_op1=alu_res combinationally, next chunk on alu_op2.
  - Stay in RESULT; each further pass costs 1 cycle.
  - Latency N+2 cycles.
- Undefined: 2 cycles per pass, latency 2N+1 as above.
- Both builds: identical results; N=1 latency is 3 in either build.

Test Plan:
- ADD rs1=0xFFFFFFFF, rs2=1, rd=3 → wb_data=0, wb_carry=1, wb_z=1, wb_rd=3, wb_valid at accept+3.
- SLLI rs1=1, imm=31 → 5 alu_EX pulses with op2=7,7,7,7,3; wb_data=0x80000000; wb_valid at accept+11 (accept+7 with ALU_SEQ_CHAIN_EN).
- SRAI rs1=0x80000000, imm=8 → passes 7,1; wb_data=0xFF800000.
- SLTI rs1=5, imm=0x0009 → wb_data=all-ones pattern from ALU (0xFFFFFFFF), wb_carry=0; ANDI rs1=0xFFFFFFFF, imm=0x8000 → wb_data=0x00008000.
- Opcode 0x3F → illegal pulse 1 cycle, no alu_EX, no wb_valid, instr_ready stays 1.
- wb_ready held 0 for 5 cycles with wb_data=0x1234 → wb outputs stable, instr_ready=0; rst asserted mid-shift → next cycle IDLE, wb_valid=0, alu_EX=0.
